binary_morph_3x3: RTL and testbench
===================================

Name: binary_morph_3x3

Overview:
- Downstream stage of the adaptive-thresholding block.
- Reads the binary image that stage writes (0 / 255 per pixel) from frame memory.
- Applies a 3x3 morphological erosion or dilation to clean speckle.
- Writes the result to an output frame buffer, using the same Go/Done and pixel-memory handshake as the rest of the 4-procedure pipeline.

Parameters:
A_WIDTH, 17, pixel-memory address width
D_WIDTH, 8, pixel data width
ROW, 320, frame rows (Y range 0..ROW-1)
COL, 240, frame columns (X range 0..COL-1); linear address = Y*COL+X

Ports:
Clk  input  1  clock, all state updates on rising edge
Rst  input  1  asynchronous, active-low reset
Go  input  1  start request, sampled only in IDLE
Mode  input  1  0 = erode, 1 = dilate; latched on accepted Go
P_Data  input  D_WIDTH  read data from binary image memory
P_Addr  output  A_WIDTH  read address to binary image memory
I_En  output  1  read enable
I_RW  output  1  read/write select, tied 0 (read)
B_Addr  output  A_WIDTH  write address to output buffer
M_Out  output  D_WIDTH  write data, 0 or 255
O_En  output  1  write enable
O_RW  output  1  1 while O_En high, else 0
Done  output  1  one-cycle completion pulse

Behaviour:
- Reset (Rst=0, any time, asynchronous):
  - state to IDLE; X, Y, neighbour index, accumulator cleared.
  - All outputs 0.
  - A frame in progress is abandoned; no further write is issued.
- Memory timing: synchronous read. Data for the address presented with I_En=1 in cycle t is valid on P_Data in cycle t+1.
- Outputs are Moore, decoded from state; addresses are registered.
- FSM:
  - IDLE: Go=1 -> INIT and latch Mode; else stay.
  - INIT: Y=0 -> ROW_CHK.
  - ROW_CHK: Y<ROW -> X=0, COL_CHK; else DONE.
  - COL_CHK: X<COL -> set accumulator (erode: 1, dilate: 0), neighbour k=0 -> NB_ISSUE; else ROW_INC.
  - NB_ISSUE: dy=k/3-1, dx=k%3-1.
    - If Y+dy and X+dx are both in bounds: P_Addr=(Y+dy)*COL+(X+dx), I_En=1.
    - Else: I_En=0, P_Addr holds.
    - Next state: NB_ACC.
  - NB_ACC: only if the neighbour was in bounds, bit = (P_Data != 0).
    - Erode: acc &= bit. Dilate: acc |= bit.
    - Out-of-bounds neighbours leave acc unchanged.
    - k<8 -> k++, NB_ISSUE; k==8 -> WRITE.
  - WRITE: B_Addr=Y*COL+X, M_Out = acc ? 255 : 0, O_En=1, O_RW=1; X++ -> COL_CHK.
  - ROW_INC: Y++ -> ROW_CHK.
  - DONE: Done=1 for one cycle -> IDLE.
- Fixed cost of 20 cycles per pixel, independent of data or border position; there is no early exit.
- Done rises exactly ROW*(COL*20+3)+2 rising edges after the edge that samples Go.
- Go is ignored outside IDLE. Mode changes after acceptance have no effect.
- Any nonzero P_Data counts as foreground.
- Address arithmetic is unsigned A_WIDTH. Max address is ROW*COL-1 = 76799, which fits 17 bits.
- Exactly one write per pixel, in raster order, with no duplicate or skipped addresses.

Test Plan:
- ROW=3, COL=4, all pixels 255, Mode=0 -> 12 writes of 255 at addresses 0..11; Done 251 cycles after Go edge.
- ROW=3, COL=4, only (Y1,X1)=255, Mode=1 -> 255 at addresses 0,1,2,4,5,6,8,9,10; 0 at 3,7,11.
- Same image, Mode=0 -> all 12 writes are 0. Corner (0,0) read count is 4 (I_En pulses), interior pixel read count is 9.
- Image of value 1 everywhere except (2,3)=0, Mode=0 -> writes of 0 at addresses 6,7,10,11; 255 elsewhere.
- Go pulsed again mid-frame with Mode toggled -> no restart, result matches the original Mode, single Done.
- Rst pulled low during the 5th pixel -> outputs 0 immediately and no further O_En. A new Go then gives the full 251-cycle frame starting from B_Addr 0.

Source files
------------

// File: rtl/binary_morph_3x3.sv
// binary_morph_3x3: 3x3 binary erosion/dilation over a ROW x COL frame.
// Reads the thresholded image through a synchronous-read pixel memory and
// writes one 0/255 result per pixel, in raster order, to the output buffer.
// Every pixel costs a fixed 20 cycles (9 neighbour issue/accumulate pairs
// plus column check and write), regardless of data or border position.
//
// Ports:
//   Clk, Rst       clock, asynchronous active-low reset
//   Go, Mode       start request (IDLE only); 0 = erode, 1 = dilate
//   P_Data         read data, valid the cycle after I_En
//   P_Addr, I_En   read address / enable; I_RW is tied to read (0)
//   B_Addr, M_Out  write address / data (0 or 255)
//   O_En, O_RW     write enable / write select (equal to each other)
//   Done           one-cycle completion pulse
module binary_morph_3x3 #(
    parameter int unsigned A_WIDTH = 17,
    parameter int unsigned D_WIDTH = 8,
    parameter int unsigned ROW     = 320,
    parameter int unsigned COL     = 240
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Go,
    input  logic               Mode,
    input  logic [D_WIDTH-1:0] P_Data,
    output logic [A_WIDTH-1:0] P_Addr,
    output logic               I_En,
    output logic               I_RW,
    output logic [A_WIDTH-1:0] B_Addr,
    output logic [D_WIDTH-1:0] M_Out,
    output logic               O_En,
    output logic               O_RW,
    output logic               Done
);

    localparam int unsigned Y_W = $clog2(ROW + 1);
    localparam int unsigned X_W = $clog2(COL + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_ROW_CHK,
        S_COL_CHK,
        S_NB_ISSUE,
        S_NB_ACC,
        S_WRITE,
        S_ROW_INC,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [Y_W-1:0]     r_y;
    logic [X_W-1:0]     r_x;
    logic [3:0]         r_k;
    logic               r_acc;
    logic               r_mode;
    logic               r_nb_valid;

    logic [3:0]         w_nk;
    logic [1:0]         w_dy;
    logic [1:0]         w_dx;
    logic               w_nb_valid;
    logic [A_WIDTH-1:0] w_pix_addr;
    logic [A_WIDTH-1:0] w_nb_addr;
    logic               w_bit;
    logic               w_acc_next;

    assign I_RW = 1'b0;

    // Neighbour about to be issued: k=0 when entering from COL_CHK, else k+1.
    // dy/dx are kept as 0..2 offsets so the address math stays unsigned.
    always_comb begin
        w_nk = (r_state == S_NB_ACC) ? r_k + 4'd1 : 4'd0;
        w_dy = 2'd2;
        w_dx = 2'd2;
        case (w_nk)
            4'd0:    begin w_dy = 2'd0; w_dx = 2'd0; end
            4'd1:    begin w_dy = 2'd0; w_dx = 2'd1; end
            4'd2:    begin w_dy = 2'd0; w_dx = 2'd2; end
            4'd3:    begin w_dy = 2'd1; w_dx = 2'd0; end
            4'd4:    begin w_dy = 2'd1; w_dx = 2'd1; end
            4'd5:    begin w_dy = 2'd1; w_dx = 2'd2; end
            4'd6:    begin w_dy = 2'd2; w_dx = 2'd0; end
            4'd7:    begin w_dy = 2'd2; w_dx = 2'd1; end
            default: begin w_dy = 2'd2; w_dx = 2'd2; end
        endcase

        w_nb_valid = !((w_dy == 2'd0) && (r_y == '0))
                  && !((w_dy == 2'd2) && (r_y == Y_W'(ROW - 1)))
                  && !((w_dx == 2'd0) && (r_x == '0))
                  && !((w_dx == 2'd2) && (r_x == X_W'(COL - 1)));

        w_pix_addr = A_WIDTH'(r_y) * A_WIDTH'(COL) + A_WIDTH'(r_x);
        // Only used when in bounds, so the -COL-1 bias never underflows.
        w_nb_addr  = w_pix_addr + A_WIDTH'(w_dy) * A_WIDTH'(COL) + A_WIDTH'(w_dx)
                   - A_WIDTH'(COL) - A_WIDTH'(1);

        w_bit      = (P_Data != '0);
        w_acc_next = !r_nb_valid ? r_acc
                   : (r_mode ? (r_acc | w_bit) : (r_acc & w_bit));
    end

    // Controller; outputs are set on the edge that enters the state they belong to.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state    <= S_IDLE;
            r_y        <= '0;
            r_x        <= '0;
            r_k        <= '0;
            r_acc      <= 1'b0;
            r_mode     <= 1'b0;
            r_nb_valid <= 1'b0;
            P_Addr     <= '0;
            I_En       <= 1'b0;
            B_Addr     <= '0;
            M_Out      <= '0;
            O_En       <= 1'b0;
            O_RW       <= 1'b0;
            Done       <= 1'b0;
        end else begin
            I_En <= 1'b0;
            O_En <= 1'b0;
            O_RW <= 1'b0;
            Done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (Go) begin
                        r_mode  <= Mode;
                        r_state <= S_INIT;
                    end
                end
                S_INIT: begin
                    r_y     <= '0;
                    r_state <= S_ROW_CHK;
                end
                S_ROW_CHK: begin
                    if (r_y < Y_W'(ROW)) begin
                        r_x     <= '0;
                        r_state <= S_COL_CHK;
                    end else begin
                        Done    <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_COL_CHK: begin
                    if (r_x < X_W'(COL)) begin
                        r_acc      <= ~r_mode;
                        r_k        <= '0;
                        r_nb_valid <= w_nb_valid;
                        I_En       <= w_nb_valid;
                        if (w_nb_valid) P_Addr <= w_nb_addr;
                        r_state    <= S_NB_ISSUE;
                    end else begin
                        r_state <= S_ROW_INC;
                    end
                end
                S_NB_ISSUE: begin
                    r_state <= S_NB_ACC;
                end
                S_NB_ACC: begin
                    r_acc <= w_acc_next;
                    if (r_k == 4'd8) begin
                        B_Addr  <= w_pix_addr;
                        M_Out   <= w_acc_next ? D_WIDTH'(255) : '0;
                        O_En    <= 1'b1;
                        O_RW    <= 1'b1;
                        r_state <= S_WRITE;
                    end else begin
                        r_k        <= r_k + 4'd1;
                        r_nb_valid <= w_nb_valid;
                        I_En       <= w_nb_valid;
                        if (w_nb_valid) P_Addr <= w_nb_addr;
                        r_state    <= S_NB_ISSUE;
                    end
                end
                S_WRITE: begin
                    r_x     <= r_x + X_W'(1);
                    r_state <= S_COL_CHK;
                end
                S_ROW_INC: begin
                    r_y     <= r_y + Y_W'(1);
                    r_state <= S_ROW_CHK;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_binary_morph_3x3.sv
// Testbench for binary_morph_3x3 on a 3x4 frame: table vectors, Go/Mode
// interference, mid-frame reset and random images against a 2D model.
module tb_binary_morph_3x3;

    localparam int ROW       = 3;
    localparam int COL       = 4;
    localparam int AW        = 17;
    localparam int DW        = 8;
    localparam int NPIX      = ROW * COL;
    localparam int FRAME_CYC = ROW * (COL * 20 + 3) + 2;

    logic          Clk = 1'b0;
    logic          Rst = 1'b0;
    logic          Go = 1'b0;
    logic          Mode = 1'b0;
    logic [DW-1:0] P_Data = '0;
    logic [AW-1:0] P_Addr;
    logic          I_En;
    logic          I_RW;
    logic [AW-1:0] B_Addr;
    logic [DW-1:0] M_Out;
    logic          O_En;
    logic          O_RW;
    logic          Done;

    binary_morph_3x3 #(.A_WIDTH(AW), .D_WIDTH(DW), .ROW(ROW), .COL(COL)) dut (
        .Clk(Clk), .Rst(Rst), .Go(Go), .Mode(Mode), .P_Data(P_Data),
        .P_Addr(P_Addr), .I_En(I_En), .I_RW(I_RW), .B_Addr(B_Addr),
        .M_Out(M_Out), .O_En(O_En), .O_RW(O_RW), .Done(Done)
    );

    always #5 Clk = ~Clk;

    logic [DW-1:0] mem [NPIX];
    int wr_addr [$];
    int wr_data [$];
    int wr_reads [$];
    int rd_since  = 0;
    int done_cnt  = 0;
    int proto_err = 0;
    int n_cmp = 0;
    int n_bad = 0;

    // Synchronous-read image memory.
    always @(posedge Clk) begin
        if (I_En) P_Data <= (int'(P_Addr) < NPIX) ? mem[int'(P_Addr)] : 8'hxx;
    end

    // Bus observer.
    always @(posedge Clk) begin
        if (Rst) begin
            if (I_RW !== 1'b0 || O_RW !== O_En || (I_En && O_En)) proto_err++;
            if (I_En) rd_since++;
            if (O_En) begin
                wr_addr.push_back(int'(B_Addr));
                wr_data.push_back(int'(M_Out));
                wr_reads.push_back(rd_since);
                rd_since = 0;
            end
            if (Done) done_cnt++;
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [NPIX-1:0] model_mask(input bit mode);
        logic [NPIX-1:0] res;
        res = '0;
        for (int y = 0; y < ROW; y++) begin
            for (int x = 0; x < COL; x++) begin
                bit any_fg = 1'b0;
                bit all_fg = 1'b1;
                for (int yy = y - 1; yy <= y + 1; yy++) begin
                    for (int xx = x - 1; xx <= x + 1; xx++) begin
                        if (yy >= 0 && yy < ROW && xx >= 0 && xx < COL) begin
                            any_fg |= (mem[yy * COL + xx] != 0);
                            all_fg &= (mem[yy * COL + xx] != 0);
                        end
                    end
                end
                res[y * COL + x] = mode ? any_fg : all_fg;
            end
        end
        return res;
    endfunction

    function automatic int nb_count(input int p);
        int y = p / COL;
        int x = p % COL;
        int n = 0;
        for (int yy = y - 1; yy <= y + 1; yy++)
            for (int xx = x - 1; xx <= x + 1; xx++)
                if (yy >= 0 && yy < ROW && xx >= 0 && xx < COL) n++;
        return n;
    endfunction

    task automatic clear_obs();
        wr_addr.delete();
        wr_data.delete();
        wr_reads.delete();
        rd_since = 0;
        done_cnt = 0;
    endtask

    // Starts a frame, flips Mode right after acceptance, optionally pulses Go
    // again with Mode flipped at edge inject_at, and counts edges to Done.
    task automatic do_frame(input bit mode, input int inject_at, output int cycles);
        clear_obs();
        @(negedge Clk);
        Go   = 1'b1;
        Mode = mode;
        @(posedge Clk);
        @(negedge Clk);
        Go   = 1'b0;
        Mode = ~mode;
        cycles = -1;
        for (int n = 1; n <= 3000; n++) begin
            @(posedge Clk);
            #1;
            Go = 1'b0;
            if (n == inject_at) begin
                Go   = 1'b1;
                Mode = ~Mode;
            end
            if (Done) begin
                cycles = n;
                break;
            end
        end
        Go = 1'b0;
    endtask

    task automatic check_frame(input string tag, input logic [NPIX-1:0] exp_mask,
                               input int cycles, input int settle);
        repeat (settle) @(posedge Clk);
        #1;
        chk({tag, " cycles"}, cycles, FRAME_CYC);
        chk({tag, " done_pulses"}, done_cnt, 1);
        chk({tag, " writes"}, wr_addr.size(), NPIX);
        for (int i = 0; i < NPIX && i < wr_addr.size(); i++) begin
            chk($sformatf("%s addr[%0d]", tag, i), wr_addr[i], i);
            chk($sformatf("%s data[%0d]", tag, i), wr_data[i], exp_mask[i] ? 255 : 0);
            chk($sformatf("%s reads[%0d]", tag, i), wr_reads[i], nb_count(i));
        end
    endtask

    task automatic check_zero(input string tag);
        chk(tag, longint'({P_Addr, I_En, I_RW, B_Addr, M_Out, O_En, O_RW, Done}), 0);
    endtask

    typedef struct {
        logic [NPIX-1:0] fg_mask;
        logic [DW-1:0]   fg_val;
        bit              mode;
        logic [NPIX-1:0] exp_mask;
    } vec_t;

    vec_t vecs [7];

    task automatic load_vec(input vec_t v);
        for (int i = 0; i < NPIX; i++) mem[i] = v.fg_mask[i] ? v.fg_val : 8'd0;
    endtask

    initial begin
        int cyc;
        int dens;
        bit md;

        vecs[0] = '{12'hFFF, 8'd255, 1'b0, 12'hFFF};
        vecs[1] = '{12'h020, 8'd255, 1'b1, 12'h777};
        vecs[2] = '{12'h020, 8'd255, 1'b0, 12'h000};
        vecs[3] = '{12'h7FF, 8'd1,   1'b0, 12'h33F};
        vecs[4] = '{12'h000, 8'd255, 1'b1, 12'h000};
        vecs[5] = '{12'hFFF, 8'd128, 1'b1, 12'hFFF};
        vecs[6] = '{12'h001, 8'd255, 1'b1, 12'h033};

        repeat (3) @(posedge Clk);
        #1;
        check_zero("reset_outputs");
        @(negedge Clk);
        Rst = 1'b1;

        for (int v = 0; v < 7; v++) begin
            load_vec(vecs[v]);
            do_frame(vecs[v].mode, 0, cyc);
            check_frame($sformatf("vec%0d", v), vecs[v].exp_mask, cyc, 4);
        end

        // Second Go with flipped Mode mid-frame must be ignored.
        load_vec(vecs[1]);
        do_frame(1'b1, 60, cyc);
        check_frame("go_midframe", 12'h777, cyc, 30);

        // Asynchronous reset during the fifth pixel.
        load_vec(vecs[0]);
        clear_obs();
        @(negedge Clk);
        Go   = 1'b1;
        Mode = 1'b0;
        @(negedge Clk);
        Go = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(posedge Clk);
            #1;
            if (wr_addr.size() >= 4) break;
        end
        chk("rst_prewrites", wr_addr.size(), 4);
        repeat (5) @(posedge Clk);
        #2;
        Rst = 1'b0;
        #1;
        check_zero("rst_async_outputs");
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b1;
        repeat (20) @(posedge Clk);
        #1;
        chk("rst_no_more_writes", wr_addr.size(), 4);
        chk("rst_no_done", done_cnt, 0);
        do_frame(1'b0, 0, cyc);
        check_frame("after_rst", 12'hFFF, cyc, 4);

        // Random images against the model.
        for (int r = 0; r < 10; r++) begin
            dens = $urandom_range(20, 90);
            for (int i = 0; i < NPIX; i++)
                mem[i] = ($urandom_range(0, 99) < dens) ? 8'($urandom_range(1, 255)) : 8'd0;
            md = 1'($urandom_range(0, 1));
            do_frame(md, 0, cyc);
            check_frame($sformatf("rand%0d", r), model_mask(md), cyc, 4);
        end

        chk("protocol_errors", proto_err, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
